// File: rtl/sq_multi_if.sv
// D-cache store port between the store queue and the cache.
// The queue drives the request side; the cache returns the accept.
interface sq_multi_if;
    logic        st_req;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic        st_ack;

    modport master (
        output st_req,
        output st_addr,
        output st_data,
        input  st_ack
    );

    modport slave (
        input  st_req,
        input  st_addr,
        input  st_data,
        output st_ack
    );
endinterface

// File: rtl/sq_multi.sv
// Parametrised store queue: multi-slot dispatch, CDB snooping,
// in-order commit to the D-cache and store-to-load forwarding.
module sq_multi #(
    parameter int DEPTH    = 16,
    parameter int DISP_W   = 2,
    parameter int CDB_N    = 2,
    parameter int ROB_BITS = 5,
    parameter int PRN_BITS = 7,
    parameter int IDX_BITS = $clog2(DEPTH)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DISP_W-1:0]          disp_valid,
    input  logic [DISP_W*ROB_BITS-1:0] disp_rob,
    input  logic [DISP_W-1:0]          disp_val_rdy,
    input  logic [DISP_W*64-1:0]       disp_val,
    input  logic [DISP_W*PRN_BITS-1:0] disp_val_tag,
    input  logic [DISP_W-1:0]          disp_base_rdy,
    input  logic [DISP_W*64-1:0]       disp_base,
    input  logic [DISP_W*PRN_BITS-1:0] disp_base_tag,
    input  logic [DISP_W*64-1:0]       disp_offset,
    input  logic [CDB_N-1:0]           cdb_valid,
    input  logic [CDB_N*PRN_BITS-1:0]  cdb_tag,
    input  logic [CDB_N*64-1:0]        cdb_data,
    input  logic [ROB_BITS-1:0]        rob_head,
    input  logic                       mispredict,
    input  logic                       ld_valid,
    input  logic [63:0]                ld_addr,
    input  logic [IDX_BITS:0]          ld_sq_tail,
    sq_multi_if.master                 st,
    output logic [IDX_BITS:0]          tail_index,
    output logic [IDX_BITS:0]          free_cnt,
    output logic                       full,
    output logic                       fwd_hit,
    output logic [63:0]                fwd_data,
    output logic                       fwd_stall
);

    localparam int PW = IDX_BITS + 1;
    localparam int SW = (DISP_W > 1) ? $clog2(DISP_W) : 1;

    typedef logic [PW-1:0] ptr_t;

    ptr_t head;
    ptr_t tail;
    ptr_t free_q;

    logic [DEPTH-1:0]    valid;
    logic [DEPTH-1:0]    committed;
    logic [DEPTH-1:0]    val_rdy;
    logic [DEPTH-1:0]    base_rdy;
    logic [DEPTH-1:0]    addr_rdy;
    logic [63:0]         val_q    [DEPTH];
    logic [63:0]         base_q   [DEPTH];
    logic [63:0]         off_q    [DEPTH];
    logic [63:0]         addr_q   [DEPTH];
    logic [PRN_BITS-1:0] val_tag  [DEPTH];
    logic [PRN_BITS-1:0] base_tag [DEPTH];
    logic [ROB_BITS-1:0] rob_q    [DEPTH];

    function automatic logic [64:0] snoop(
        input logic [PRN_BITS-1:0]       t,
        input logic [CDB_N-1:0]          v,
        input logic [CDB_N*PRN_BITS-1:0] tags,
        input logic [CDB_N*64-1:0]       data
    );
        logic [64:0] r;
        r = '0;
        for (int b = 0; b < CDB_N; b++) begin
            if (v[b] && tags[b*PRN_BITS +: PRN_BITS] == t)
                r = {1'b1, data[b*64 +: 64]};
        end
        return r;
    endfunction

    logic [IDX_BITS-1:0] hidx;
    logic                st_req_w;
    logic                retire;
    logic                commit_now;
    logic                accept;

    assign hidx     = head[IDX_BITS-1:0];
    assign st_req_w = valid[hidx] & committed[hidx];
    assign retire   = st_req_w & st.st_ack;
    assign accept   = !full && !mispredict;

    // A flush in the same cycle blocks commit so tail recovery stays exact
    assign commit_now = !mispredict && valid[hidx] && !committed[hidx] &&
                        addr_rdy[hidx] && val_rdy[hidx] &&
                        (rob_q[hidx] == rob_head);

    logic [64:0]         val_snp  [DEPTH];
    logic [64:0]         base_snp [DEPTH];
    logic [DISP_W-1:0]   s_vrdy;
    logic [DISP_W-1:0]   s_brdy;
    logic [63:0]         s_val    [DISP_W];
    logic [63:0]         s_base   [DISP_W];
    logic [63:0]         s_off    [DISP_W];
    logic [PRN_BITS-1:0] s_vtag   [DISP_W];
    logic [PRN_BITS-1:0] s_btag   [DISP_W];
    logic [ROB_BITS-1:0] s_rob    [DISP_W];
    logic [64:0]         dv_snp;
    logic [64:0]         db_snp;

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            val_snp[e]  = snoop(val_tag[e], cdb_valid, cdb_tag, cdb_data);
            base_snp[e] = snoop(base_tag[e], cdb_valid, cdb_tag, cdb_data);
        end
    end

    // Per-slot payload with same-cycle CDB bypass folded in
    always_comb begin
        dv_snp = '0;
        db_snp = '0;
        for (int s = 0; s < DISP_W; s++) begin
            dv_snp = snoop(disp_val_tag[s*PRN_BITS +: PRN_BITS],
                           cdb_valid, cdb_tag, cdb_data);
            db_snp = snoop(disp_base_tag[s*PRN_BITS +: PRN_BITS],
                           cdb_valid, cdb_tag, cdb_data);
            s_vtag[s] = disp_val_tag[s*PRN_BITS +: PRN_BITS];
            s_btag[s] = disp_base_tag[s*PRN_BITS +: PRN_BITS];
            s_rob[s]  = disp_rob[s*ROB_BITS +: ROB_BITS];
            s_off[s]  = disp_offset[s*64 +: 64];
            s_vrdy[s] = disp_val_rdy[s] | dv_snp[64];
            s_brdy[s] = disp_base_rdy[s] | db_snp[64];
            s_val[s]  = disp_val_rdy[s] ? disp_val[s*64 +: 64]
                                        : dv_snp[63:0];
            s_base[s] = disp_base_rdy[s] ? disp_base[s*64 +: 64]
                                         : db_snp[63:0];
        end
    end

    logic [DEPTH-1:0] wr_en;
    logic [SW-1:0]    wr_slot [DEPTH];
    ptr_t             disp_cnt;
    ptr_t             slot_p;

    always_comb begin
        wr_en    = '0;
        disp_cnt = '0;
        slot_p   = '0;
        for (int e = 0; e < DEPTH; e++)
            wr_slot[e] = '0;
        for (int s = 0; s < DISP_W; s++) begin
            if (accept && disp_valid[s]) begin
                slot_p = tail + disp_cnt;
                wr_en[slot_p[IDX_BITS-1:0]]   = 1'b1;
                wr_slot[slot_p[IDX_BITS-1:0]] = SW'(s);
                disp_cnt = disp_cnt + ptr_t'(1);
            end
        end
    end

    ptr_t head_nxt;
    ptr_t tail_nxt;
    ptr_t occ_nxt;

    assign head_nxt = head + ptr_t'(retire);
    assign tail_nxt = mispredict ? head + ptr_t'(st_req_w)
                                 : tail + disp_cnt;
    assign occ_nxt  = tail_nxt - head_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head   <= '0;
            tail   <= '0;
            free_q <= ptr_t'(DEPTH);
        end else begin
            head   <= head_nxt;
            tail   <= tail_nxt;
            free_q <= ptr_t'(DEPTH) - occ_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid     <= '0;
            committed <= '0;
            val_rdy   <= '0;
            base_rdy  <= '0;
            addr_rdy  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                val_q[e]    <= '0;
                base_q[e]   <= '0;
                off_q[e]    <= '0;
                addr_q[e]   <= '0;
                val_tag[e]  <= '0;
                base_tag[e] <= '0;
                rob_q[e]    <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wr_en[e]) begin
                    valid[e]     <= 1'b1;
                    committed[e] <= 1'b0;
                    addr_rdy[e]  <= 1'b0;
                    val_rdy[e]   <= s_vrdy[wr_slot[e]];
                    base_rdy[e]  <= s_brdy[wr_slot[e]];
                    val_q[e]     <= s_val[wr_slot[e]];
                    base_q[e]    <= s_base[wr_slot[e]];
                    off_q[e]     <= s_off[wr_slot[e]];
                    val_tag[e]   <= s_vtag[wr_slot[e]];
                    base_tag[e]  <= s_btag[wr_slot[e]];
                    rob_q[e]     <= s_rob[wr_slot[e]];
                end else begin
                    if (valid[e] && !val_rdy[e] && val_snp[e][64]) begin
                        val_rdy[e] <= 1'b1;
                        val_q[e]   <= val_snp[e][63:0];
                    end
                    if (valid[e] && !base_rdy[e] && base_snp[e][64]) begin
                        base_rdy[e] <= 1'b1;
                        base_q[e]   <= base_snp[e][63:0];
                    end
                    if (valid[e] && base_rdy[e] && !addr_rdy[e]) begin
                        addr_q[e]   <= base_q[e] + off_q[e];
                        addr_rdy[e] <= 1'b1;
                    end
                    if (commit_now && e == int'(hidx))
                        committed[e] <= 1'b1;
                    if (retire && e == int'(hidx)) begin
                        valid[e]     <= 1'b0;
                        committed[e] <= 1'b0;
                    end else if (mispredict && !committed[e]) begin
                        valid[e] <= 1'b0;
                    end
                end
            end
        end
    end

    ptr_t        f_occ;
    ptr_t        f_lim;
    ptr_t        f_p;
    logic        f_unres;
    logic        f_match;
    logic        f_mrdy;
    logic [63:0] f_mdata;

    // Oldest-to-youngest scan so the last match seen is the youngest;
    // a snapshot behind head yields a span larger than occupancy.
    always_comb begin
        f_occ   = tail - head;
        f_lim   = ld_sq_tail - head;
        f_p     = '0;
        f_unres = 1'b0;
        f_match = 1'b0;
        f_mrdy  = 1'b0;
        f_mdata = '0;
        if (f_lim > f_occ)
            f_lim = '0;
        for (int k = 0; k < DEPTH; k++) begin
            f_p = head + ptr_t'(k);
            if (ptr_t'(k) < f_lim && valid[f_p[IDX_BITS-1:0]]) begin
                if (!addr_rdy[f_p[IDX_BITS-1:0]]) begin
                    f_unres = 1'b1;
                end else if (addr_q[f_p[IDX_BITS-1:0]] == ld_addr) begin
                    f_match = 1'b1;
                    f_mrdy  = val_rdy[f_p[IDX_BITS-1:0]];
                    f_mdata = val_q[f_p[IDX_BITS-1:0]];
                end
            end
        end
    end

    assign fwd_stall = ld_valid & (f_unres | (f_match & ~f_mrdy));
    assign fwd_hit   = ld_valid & ~f_unres & f_match & f_mrdy;
    assign fwd_data  = fwd_hit ? f_mdata : 64'd0;

    assign st.st_req   = st_req_w;
    assign st.st_addr  = addr_q[hidx];
    assign st.st_data  = val_q[hidx];
    assign tail_index  = tail;
    assign free_cnt    = free_q;
    assign full        = free_q < PW'(DISP_W);

endmodule

// File: tb/tb_sq_multi.sv
// Bench for sq_multi: queue-level reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_sq_multi;
    localparam int D  = 8;
    localparam int W  = 2;
    localparam int CN = 2;
    localparam int RB = 5;
    localparam int PB = 7;
    localparam int IB = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]    disp_valid, disp_val_rdy, disp_base_rdy;
    logic [W*RB-1:0] disp_rob;
    logic [W*64-1:0] disp_val, disp_base, disp_offset;
    logic [W*PB-1:0] disp_val_tag, disp_base_tag;
    logic [CN-1:0]    cdb_valid;
    logic [CN*PB-1:0] cdb_tag;
    logic [CN*64-1:0] cdb_data;
    logic [RB-1:0] rob_head;
    logic          mispredict, ld_valid;
    logic [63:0]   ld_addr;
    logic [IB:0]   ld_sq_tail;
    logic [IB:0]   tail_index, free_cnt;
    logic          full, fwd_hit, fwd_stall;
    logic [63:0]   fwd_data;

    sq_multi_if st();

    sq_multi #(.DEPTH(D), .DISP_W(W), .CDB_N(CN),
               .ROB_BITS(RB), .PRN_BITS(PB)) dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_rob(disp_rob),
        .disp_val_rdy(disp_val_rdy), .disp_val(disp_val),
        .disp_val_tag(disp_val_tag), .disp_base_rdy(disp_base_rdy),
        .disp_base(disp_base), .disp_base_tag(disp_base_tag),
        .disp_offset(disp_offset), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rob_head(rob_head), .mispredict(mispredict),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_sq_tail(ld_sq_tail), .st(st.master),
        .tail_index(tail_index), .free_cnt(free_cnt), .full(full),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  rob;
        bit          vk;
        logic [63:0] val;
        logic [6:0]  vtag;
        bit          bk;
        logic [63:0] base;
        logic [6:0]  btag;
        logic [63:0] off;
        bit          ak;
        bit          cm;
    } ent_t;

    ent_t mq[$];
    int   mhead = 0;

    function automatic bit bus(input logic [6:0] t, output logic [63:0] d);
        bit h;
        h = 0;
        d = '0;
        for (int b = 0; b < CN; b++)
            if (cdb_valid[b] && cdb_tag[b*PB +: PB] == t) begin
                h = 1;
                d = cdb_data[b*64 +: 64];
            end
        return h;
    endfunction

    task automatic model_step();
        bit ret, cmt, keep;
        int old_sz;
        logic [63:0] d;
        ent_t e;
        old_sz = mq.size();
        ret  = old_sz > 0 && mq[0].cm && st.st_ack;
        cmt  = !mispredict && old_sz > 0 && !mq[0].cm && mq[0].ak &&
               mq[0].vk && mq[0].rob == rob_head;
        keep = old_sz > 0 && mq[0].cm && !ret;
        for (int i = 0; i < old_sz; i++) begin
            e = mq[i];
            if (e.bk) e.ak = 1;
            if (!e.vk && bus(e.vtag, d)) begin e.vk = 1; e.val = d; end
            if (!e.bk && bus(e.btag, d)) begin e.bk = 1; e.base = d; end
            if (i == 0 && cmt) e.cm = 1;
            mq[i] = e;
        end
        if (ret) begin
            mq.delete(0);
            mhead++;
        end
        if (mispredict) begin
            while (mq.size() > (keep ? 1 : 0)) mq.delete(mq.size() - 1);
        end else if (D - old_sz >= W) begin
            for (int s = 0; s < W; s++) begin
                if (disp_valid[s]) begin
                    e.rob  = disp_rob[s*RB +: RB];
                    e.vk   = disp_val_rdy[s];
                    e.val  = disp_val[s*64 +: 64];
                    e.vtag = disp_val_tag[s*PB +: PB];
                    e.bk   = disp_base_rdy[s];
                    e.base = disp_base[s*64 +: 64];
                    e.btag = disp_base_tag[s*PB +: PB];
                    e.off  = disp_offset[s*64 +: 64];
                    e.ak   = 0;
                    e.cm   = 0;
                    if (!e.vk && bus(e.vtag, d)) begin e.vk = 1; e.val = d; end
                    if (!e.bk && bus(e.btag, d)) begin e.bk = 1; e.base = d; end
                    mq.push_back(e);
                end
            end
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            mhead = 0;
        end else begin
            model_step();
        end
    end

    task automatic compare();
        int occ, lim;
        bit er, un, mt, mr, eh;
        logic [63:0] md;
        occ = mq.size();
        chk("tail_index", tail_index, 64'((mhead + occ) % 16));
        chk("free_cnt", free_cnt, 64'(D - occ));
        chk("full", full, 64'((D - occ) < W));
        er = occ > 0 && mq[0].cm;
        chk("st_req", st.st_req, 64'(er));
        if (er) begin
            chk("st_addr", st.st_addr, mq[0].base + mq[0].off);
            chk("st_data", st.st_data, mq[0].val);
        end
        un = 0; mt = 0; mr = 0; md = '0;
        if (ld_valid) begin
            lim = (int'(ld_sq_tail) - (mhead % 16) + 16) % 16;
            if (lim > occ) lim = 0;
            for (int i = 0; i < lim; i++) begin
                if (!mq[i].ak) un = 1;
                else if (mq[i].base + mq[i].off == ld_addr) begin
                    mt = 1; mr = mq[i].vk; md = mq[i].val;
                end
            end
        end
        eh = ld_valid && !un && mt && mr;
        chk("fwd_hit", fwd_hit, 64'(eh));
        chk("fwd_stall", fwd_stall, 64'(ld_valid && (un || (mt && !mr))));
        if (eh) chk("fwd_data", fwd_data, md);
    endtask

    always @(negedge clock) if (reset) compare();

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        disp_valid = '0; disp_val_rdy = '0; disp_base_rdy = '0;
        disp_rob = '0; disp_val = '0; disp_base = '0; disp_offset = '0;
        disp_val_tag = '0; disp_base_tag = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        mispredict = 0;
    endtask

    task automatic put(input int s, input logic [4:0] rob,
                       input bit vr, input logic [63:0] v, input logic [6:0] vt,
                       input bit br, input logic [63:0] b, input logic [6:0] bt,
                       input logic [63:0] off);
        disp_valid[s]            = 1'b1;
        disp_rob[s*RB +: RB]     = rob;
        disp_val_rdy[s]          = vr;
        disp_val[s*64 +: 64]     = v;
        disp_val_tag[s*PB +: PB] = vt;
        disp_base_rdy[s]         = br;
        disp_base[s*64 +: 64]    = b;
        disp_base_tag[s*PB +: PB] = bt;
        disp_offset[s*64 +: 64]  = off;
    endtask

    task automatic cdb(input int b, input logic [6:0] t, input logic [63:0] d);
        cdb_valid[b]        = 1'b1;
        cdb_tag[b*PB +: PB] = t;
        cdb_data[b*64 +: 64] = d;
    endtask

    task automatic look(input logic [63:0] a, input logic [3:0] lt);
        ld_valid   = 1'b1;
        ld_addr    = a;
        ld_sq_tail = lt;
        #1;
    endtask

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        while (!st.st_req && n < 8) begin
            step();
            n++;
        end
        chk(nm, st.st_req, 1);
    endtask

    initial begin
        idle();
        rob_head = 5'd31;
        ld_valid = 0; ld_addr = '0; ld_sq_tail = '0;
        st.st_ack = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_free", free_cnt, 8);
        chk("rst_tail", tail_index, 0);
        chk("rst_full", full, 0);
        chk("rst_req", st.st_req, 0);
        chk("rst_hit", fwd_hit, 0);
        chk("rst_stall", fwd_stall, 0);
        reset = 1'b1;
        step();

        for (int c = 0; c < 3; c++) begin
            put(0, 5'(2*c), 0, 0, 7'(8'h60 + 4*c), 0, 0, 7'(8'h61 + 4*c), 0);
            put(1, 5'(2*c+1), 0, 0, 7'(8'h62 + 4*c), 0, 0, 7'(8'h63 + 4*c), 0);
            step(); idle();
        end
        chk("fill_tail", tail_index, 6);
        chk("fill_free", free_cnt, 2);
        chk("fill_full", full, 0);
        chk("model_free", 64'(D - mq.size()), 2);
        put(0, 5'd6, 0, 0, 7'h70, 0, 0, 7'h71, 0);
        step(); idle();
        chk("one_free", free_cnt, 1);
        chk("one_full", full, 1);
        put(0, 5'd7, 1, 1, 0, 1, 8, 0, 0);
        put(1, 5'd8, 1, 1, 0, 1, 8, 0, 0);
        step(); idle();
        chk("ign_tail", tail_index, 7);
        chk("ign_free", free_cnt, 1);
        chk("model_ign", 64'(mq.size()), 7);
        mispredict = 1; step(); idle();
        chk("flush_tail", tail_index, 0);
        chk("flush_free", free_cnt, 8);

        put(0, 5'd0, 0, 0, 7'h44, 0, 0, 7'h48, 64'd5);
        step(); idle();
        cdb(0, 7'h48, 64'h5); cdb(1, 7'h44, 64'h3);
        step(); idle();
        rob_head = 5'd0;
        step(); step();
        chk("res_req", st.st_req, 1);
        chk("res_addr", st.st_addr, 64'hA);
        chk("res_data", st.st_data, 64'h3);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("hold_req", st.st_req, 1);
            chk("hold_free", free_cnt, 7);
        end
        st.st_ack = 1; step(); st.st_ack = 0;
        chk("ack_req", st.st_req, 0);
        chk("ack_free", free_cnt, 8);
        chk("ack_tail", tail_index, 1);

        rob_head = 5'd5;
        put(0, 5'd5, 1, 64'h55, 0, 1, 64'h200, 0, 64'h8);
        put(1, 5'd6, 0, 0, 7'h20, 0, 0, 7'h21, 0);
        step(); idle();
        put(0, 5'd7, 0, 0, 7'h22, 0, 0, 7'h23, 0);
        put(1, 5'd8, 0, 0, 7'h24, 0, 0, 7'h25, 0);
        step(); idle();
        wait_req("mp_req_wait");
        chk("mp_pre_free", free_cnt, 4);
        mispredict = 1; step(); idle();
        chk("mp_tail", tail_index, 2);
        chk("mp_free", free_cnt, 7);
        chk("mp_req", st.st_req, 1);
        chk("mp_addr", st.st_addr, 64'h208);
        chk("mp_data", st.st_data, 64'h55);
        st.st_ack = 1; step(); st.st_ack = 0;
        chk("mp_drain_req", st.st_req, 0);
        chk("mp_drain_free", free_cnt, 8);

        rob_head = 5'd31;
        put(0, 5'd10, 1, 64'h11, 0, 1, 64'h100, 0, 0);
        put(1, 5'd11, 1, 64'h22, 0, 1, 64'hF0, 0, 64'h10);
        step(); idle(); step();
        look(64'h100, 4);
        chk("fwd_young_hit", fwd_hit, 1);
        chk("fwd_young_data", fwd_data, 64'h22);
        chk("fwd_young_stall", fwd_stall, 0);
        look(64'h100, 3);
        chk("fwd_old_data", fwd_data, 64'h11);
        ld_valid = 0;
        mispredict = 1; step(); idle();
        put(0, 5'd12, 1, 64'h33, 0, 0, 0, 7'h30, 0);
        put(1, 5'd13, 1, 64'h11, 0, 1, 64'h100, 0, 0);
        step(); idle();
        put(0, 5'd14, 1, 64'h22, 0, 1, 64'h100, 0, 0);
        put(1, 5'd15, 0, 0, 7'h31, 1, 64'h100, 0, 0);
        step(); idle(); step();
        look(64'h100, 5);
        chk("unres_stall", fwd_stall, 1);
        chk("unres_hit", fwd_hit, 0);
        cdb(0, 7'h30, 64'h300);
        step(); idle(); step();
        look(64'h100, 5);
        chk("resolved_hit", fwd_hit, 1);
        chk("resolved_data", fwd_data, 64'h22);
        look(64'h100, 6);
        chk("valpend_stall", fwd_stall, 1);
        chk("valpend_hit", fwd_hit, 0);
        cdb(1, 7'h31, 64'h44);
        step(); idle();
        chk("valcap_hit", fwd_hit, 1);
        chk("valcap_data", fwd_data, 64'h44);
        ld_valid = 0;
        mispredict = 1; step(); idle();
        chk("f5_free", free_cnt, 8);

        for (int i = 0; i < 12; i++) begin
            rob_head = 5'(i);
            put(0, 5'(i), 1, 64'(i + 1), 0, 1, 64'(32'h1000 + 8*i), 0, 0);
            step(); idle();
            wait_req("wrap_req");
            st.st_ack = 1; step(); st.st_ack = 0;
        end
        chk("wrap_tail", tail_index, 14);
        chk("wrap_bit_set", tail_index[3], 1);
        chk("wrap_free", free_cnt, 8);
        rob_head = 5'd31;
        put(0, 5'd20, 1, 64'hA1, 0, 1, 64'h800, 0, 0);
        put(1, 5'd21, 1, 64'hB2, 0, 1, 64'h7F8, 0, 64'h8);
        step(); idle();
        put(0, 5'd22, 1, 64'hC3, 0, 1, 64'h800, 0, 0);
        put(1, 5'd23, 1, 64'hD4, 0, 1, 64'h900, 0, 0);
        step(); idle(); step();
        chk("wrap2_tail", tail_index, 2);
        chk("wrap_bit_clr", tail_index[3], 0);
        look(64'h800, 2);
        chk("wrap_fwd_c3", fwd_data, 64'hC3);
        look(64'h800, 0);
        chk("wrap_fwd_b2", fwd_data, 64'hB2);
        look(64'h800, 15);
        chk("wrap_fwd_a1", fwd_data, 64'hA1);
        look(64'h900, 2);
        chk("wrap_fwd_d4", fwd_data, 64'hD4);
        look(64'h900, 1);
        chk("wrap_miss_hit", fwd_hit, 0);
        chk("wrap_miss_stall", fwd_stall, 0);
        ld_valid = 0;
        mispredict = 1; step(); idle();
        chk("end_free", free_cnt, 8);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
